// File: rtl/pdm_mic_receiver_pkg.sv
// pdm_mic_receiver_pkg: shared PDM receiver constants and width helpers.
package pdm_mic_receiver_pkg;

    localparam int unsigned PDM_CLK_DIV_DEF = 6;
    localparam int unsigned PDM_DECIM_DEF   = 64;
    localparam int unsigned PDM_THRESH_DEF  = 24;
    localparam int unsigned PDM_HOLDOFF_DEF = 512;
    localparam int unsigned PDM_HALF_DEF    = PDM_DECIM_DEF / 2;

    // Width needed to hold a ones count of 0..decim inclusive.
    function automatic int unsigned pdm_sample_w(input int unsigned decim);
        return $clog2(decim) + 1;
    endfunction

    // Half-scale value: the count a silent (50% density) stream produces.
    function automatic int unsigned pdm_half(input int unsigned decim);
        return decim / 2;
    endfunction

endpackage

// File: rtl/pdm_mic_receiver_clk_gen.sv
// pdm_clk_gen: microphone clock divider. Produces mic_clk and a one-cycle
// capture strobe on the cycle whose clock edge takes mic_clk from 1 to 0.
module pdm_clk_gen
    import pdm_mic_receiver_pkg::*;
#(
    parameter int unsigned CLK_DIV = PDM_CLK_DIV_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic mic_clk_o,
    output logic cap_stb_o
);
    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             mic_clk_q, mic_clk_d;
    logic             wrap;

    assign wrap = (div_cnt_q == DIV_LAST);

    // Next-state: count while enabled, toggle mic_clk on wrap, park low when disabled
    always_comb begin
        div_cnt_d = div_cnt_q;
        mic_clk_d = mic_clk_q;
        if (!en_i) begin
            div_cnt_d = '0;
            mic_clk_d = 1'b0;
        end else if (wrap) begin
            div_cnt_d = '0;
            mic_clk_d = ~mic_clk_q;
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end
    end

    // Divider state registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_cnt_q <= '0;
            mic_clk_q <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            mic_clk_q <= mic_clk_d;
        end
    end

    assign mic_clk_o = mic_clk_q;
    assign cap_stb_o = en_i & wrap & mic_clk_q;

endmodule

// File: rtl/pdm_mic_receiver.sv
// pdm_mic_receiver: PDM microphone receiver. Counts ones per DECIM-bit window,
// reports |sample - DECIM/2| as loudness and strobes clap on loud windows with
// a holdoff. Define PDM_PEAK_EN to add the peak-hold tracker (peak_clr_i/peak_o).
module pdm_mic_receiver
    import pdm_mic_receiver_pkg::*;
#(
    parameter int unsigned CLK_DIV  = PDM_CLK_DIV_DEF,
    parameter int unsigned DECIM    = PDM_DECIM_DEF,
    parameter int unsigned SAMPLE_W = pdm_sample_w(DECIM),
    parameter int unsigned THRESH   = PDM_THRESH_DEF,
    parameter int unsigned HOLDOFF  = PDM_HOLDOFF_DEF
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic                mic_data_i,
    output logic                mic_clk_o,
    output logic                mic_lrsel_o,
    output logic [SAMPLE_W-1:0] sample_o,
    output logic                sample_valid_o,
    output logic [SAMPLE_W-1:0] level_o,
    output logic                clap_o
`ifdef PDM_PEAK_EN
    ,
    input  logic                peak_clr_i,
    output logic [SAMPLE_W-1:0] peak_o
`endif
);
    localparam int unsigned BC_W = $clog2(DECIM);
    localparam int unsigned HO_W = (HOLDOFF == 0) ? 1 : $clog2(HOLDOFF + 1);
    localparam logic [SAMPLE_W-1:0] HALF     = SAMPLE_W'(pdm_half(DECIM));
    localparam logic [SAMPLE_W-1:0] THR      = SAMPLE_W'(THRESH);
    localparam logic [BC_W-1:0]     BIT_LAST = BC_W'(DECIM - 1);
    localparam logic [HO_W-1:0]     HO_LOAD  = HO_W'(HOLDOFF);

    logic                cap_stb;
    logic [1:0]          sync_q;
    logic                bit_s;
    logic                win_end;
    logic [BC_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [SAMPLE_W-1:0] ones_cnt_q, ones_cnt_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d, level_q, level_d;
    logic [SAMPLE_W-1:0] sample_new, level_new;
    logic                valid_q, valid_d, clap_q, clap_d;
    logic [HO_W-1:0]     holdoff_q, holdoff_d;

    pdm_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .en_i      (en_i),
        .mic_clk_o (mic_clk_o),
        .cap_stb_o (cap_stb)
    );

    // Two-flop synchroniser for the asynchronous mic data; free-running
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) sync_q <= '0;
        else       sync_q <= {sync_q[0], mic_data_i};
    end

    assign bit_s      = sync_q[1];
    assign win_end    = cap_stb && (bit_cnt_q == BIT_LAST);
    assign sample_new = ones_cnt_q + SAMPLE_W'(bit_s);
    assign level_new  = (sample_new >= HALF) ? (sample_new - HALF) : (HALF - sample_new);

    // Decimator, level and clap next-state; disable discards the partial window
    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        ones_cnt_d = ones_cnt_q;
        sample_d   = sample_q;
        level_d    = level_q;
        holdoff_d  = holdoff_q;
        valid_d    = 1'b0;
        clap_d     = 1'b0;
        if (!en_i) begin
            bit_cnt_d  = '0;
            ones_cnt_d = '0;
            holdoff_d  = '0;
        end else if (win_end) begin
            bit_cnt_d  = '0;
            ones_cnt_d = '0;
            sample_d   = sample_new;
            level_d    = level_new;
            valid_d    = 1'b1;
            if ((level_new >= THR) && (holdoff_q == '0)) begin
                clap_d    = 1'b1;
                holdoff_d = HO_LOAD;
            end else if (holdoff_q != '0) begin
                holdoff_d = holdoff_q - 1'b1;
            end
        end else if (cap_stb) begin
            bit_cnt_d  = bit_cnt_q + 1'b1;
            ones_cnt_d = sample_new;
        end
    end

    // Decimator, output and holdoff registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bit_cnt_q  <= '0;
            ones_cnt_q <= '0;
            sample_q   <= '0;
            level_q    <= '0;
            valid_q    <= 1'b0;
            clap_q     <= 1'b0;
            holdoff_q  <= '0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            ones_cnt_q <= ones_cnt_d;
            sample_q   <= sample_d;
            level_q    <= level_d;
            valid_q    <= valid_d;
            clap_q     <= clap_d;
            holdoff_q  <= holdoff_d;
        end
    end

    assign mic_lrsel_o    = 1'b0;
    assign sample_o       = sample_q;
    assign level_o        = level_q;
    assign sample_valid_o = valid_q;
    assign clap_o         = clap_q;

`ifdef PDM_PEAK_EN
    logic [SAMPLE_W-1:0] peak_q;

    // Peak hold of level; a clear coinciding with a fresh sample restarts from it
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            peak_q <= '0;
        end else if (peak_clr_i) begin
            peak_q <= valid_q ? level_q : '0;
        end else if (valid_q && (level_q > peak_q)) begin
            peak_q <= level_q;
        end
    end

    assign peak_o = peak_q;
`endif

endmodule

// File: tb/tb_pdm_mic_receiver.sv
`timescale 1ns/1ps
module tb_pdm_mic_receiver;
    localparam int CLK_DIV  = 3;
    localparam int DECIM    = 16;
    localparam int SAMPLE_W = 5;
    localparam int THRESH   = 4;
    localparam int HOLDOFF  = 3;
    localparam int HALF     = DECIM / 2;
    localparam int PER      = 2 * CLK_DIV;
    localparam int INF      = 1000000;

    logic clk = 1'b0;
    logic rst, en, mic_data;
    logic mic_clk, mic_lrsel, sample_valid, clap;
    logic [SAMPLE_W-1:0] sample, level;
`ifdef PDM_PEAK_EN
    logic peak_clr;
    logic [SAMPLE_W-1:0] peak;
    int peak_m = 0;
`endif

    typedef struct {int s; int l; int c;} exp_t;
    exp_t exp_q[$];
    exp_t e_cur;

    int checks = 0, errors = 0;
    int mode = 0, dens = 50;
    int n_pop = 0;
    int win_bits = 0, win_ones = 0, since_clap = INF;
    int cur_bit = 0, prev_mic = 0, en_cyc = 0, last_cap = -1;
    int last_s = 0, last_l = 0;

    pdm_mic_receiver #(
        .CLK_DIV (CLK_DIV), .DECIM (DECIM), .SAMPLE_W (SAMPLE_W),
        .THRESH (THRESH), .HOLDOFF (HOLDOFF)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .en_i           (en),
        .mic_data_i     (mic_data),
        .mic_clk_o      (mic_clk),
        .mic_lrsel_o    (mic_lrsel),
        .sample_o       (sample),
        .sample_valid_o (sample_valid),
        .level_o        (level),
        .clap_o         (clap)
`ifdef PDM_PEAK_EN
        ,
        .peak_clr_i     (peak_clr),
        .peak_o         (peak)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    function automatic int next_bit();
        case (mode)
            1:       return 1;
            2:       return 1 - cur_bit;
            3:       return 0;
            4:       return ($urandom_range(0, 99) < dens) ? 1 : 0;
            default: return int'($urandom_range(0, 1));
        endcase
    endfunction

    // Window completion: expected result from counting ones and clap spacing
    function automatic void push_expected();
        exp_t e;
        e.s = win_ones;
        e.l = (e.s >= HALF) ? e.s - HALF : HALF - e.s;
        if (since_clap < INF) since_clap++;
        e.c = (e.l >= THRESH && since_clap > HOLDOFF) ? 1 : 0;
        if (e.c == 1) since_clap = 0;
        exp_q.push_back(e);
        win_bits = 0;
        win_ones = 0;
    endfunction

    // Reference model + data driver: new bit on each mic_clk rise, counted on each fall
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                exp_q.delete();
                win_bits = 0; win_ones = 0; since_clap = INF;
                prev_mic = 0; en_cyc = 0; last_cap = -1;
                chk("mic_clk_in_reset", int'(mic_clk), 0);
                continue;
            end
            if (!en) begin
                win_bits = 0; win_ones = 0; since_clap = INF;
                en_cyc = 0; last_cap = -1;
                chk("mic_clk_disabled", int'(mic_clk), 0);
            end else begin
                en_cyc++;
                if (prev_mic == 1 && mic_clk == 1'b0) begin
                    chk("capture_spacing", (last_cap < 0) ? en_cyc : en_cyc - last_cap, PER);
                    last_cap = en_cyc;
                    win_ones += cur_bit;
                    win_bits++;
                    if (win_bits == DECIM) push_expected();
                end
                if (prev_mic == 0 && mic_clk == 1'b1) begin
                    cur_bit = next_bit();
                    mic_data = (cur_bit != 0);
                end
            end
            prev_mic = int'(mic_clk);
        end
    end

    // Monitor: pop the scoreboard whenever the DUT presents a sample
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
`ifdef PDM_PEAK_EN
                peak_m = 0;
`endif
                continue;
            end
            e_cur = '{0, 0, 0};
            if (sample_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: sample_valid=1, expected no sample (sample=%0d)", sample);
                end else begin
                    e_cur = exp_q.pop_front();
                    chk("sample", int'(sample), e_cur.s);
                    chk("level", int'(level), e_cur.l);
                    chk("clap", int'(clap), e_cur.c);
                    last_s = e_cur.s;
                    last_l = e_cur.l;
                    n_pop++;
                end
            end else begin
                chk("clap_without_valid", int'(clap), 0);
            end
`ifdef PDM_PEAK_EN
            chk("peak", int'(peak), peak_m);
            if (peak_clr) peak_m = sample_valid ? e_cur.l : 0;
            else if (sample_valid && e_cur.l > peak_m) peak_m = e_cur.l;
`endif
        end
    end

    task automatic run_windows(input int n);
        int target, k;
        target = n_pop + n;
        k = 0;
        while (n_pop < target && k < (n + 1) * PER * DECIM + 50) begin
            @(negedge clk);
            k++;
        end
        if (n_pop < target) timeout("run_windows");
    endtask

    task automatic measure_first();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!sample_valid && k < 3 * PER * DECIM);
        if (!sample_valid) timeout("first_valid");
        else chk("first_valid_latency", k, PER * DECIM);
    endtask

    task automatic wait_bits(input int n);
        int k;
        k = 0;
        while (win_bits != n && k < 2 * PER * DECIM) begin
            @(negedge clk);
            k++;
        end
        if (win_bits != n) timeout("wait_bits");
    endtask

    task automatic wait_rise();
        int k, p;
        k = 0;
        p = int'(mic_clk);
        do begin
            @(negedge clk);
            k++;
            if (mic_clk == 1'b1 && p == 0) break;
            p = int'(mic_clk);
        end while (k < 4 * PER);
        if (k >= 4 * PER) timeout("wait_rise");
    endtask

    task automatic pulse_peak_clr();
`ifdef PDM_PEAK_EN
        @(posedge clk); #2 peak_clr = 1'b1;
        @(posedge clk); #2 peak_clr = 1'b0;
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b0; mic_data = 1'b0;
`ifdef PDM_PEAK_EN
        peak_clr = 1'b0;
`endif
        #1;
        chk("reset_sample", int'(sample), 0);
        chk("reset_level", int'(level), 0);
        chk("reset_valid", int'(sample_valid), 0);
        chk("reset_clap", int'(clap), 0);
        chk("reset_mic_clk", int'(mic_clk), 0);
        chk("mic_lrsel", int'(mic_lrsel), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // random stream from a fresh enable
        mode = 0; en = 1'b1;
        measure_first();
        run_windows(3);

        // all ones: clap, holdoff suppression, clap again
        mode = 1;
        run_windows(HOLDOFF + 4);
        pulse_peak_clr();

        // alternating: half scale, silent
        mode = 2;
        run_windows(3);

        // all zeros
        mode = 3;
        run_windows(2);

        // disable mid-window: partial window discarded, outputs hold
        mode = 0;
        wait_bits(10);
        @(negedge clk); en = 1'b0;
        repeat (30) @(negedge clk);
        chk("hold_sample", int'(sample), last_s);
        chk("hold_level", int'(level), last_l);
        en = 1'b1;
        measure_first();

        // disable on the cycle of the window's last capture: no sample
        wait_bits(DECIM - 1);
        wait_rise();
        repeat (CLK_DIV - 1) @(negedge clk);
        en = 1'b0;
        repeat (20) @(negedge clk);
        chk("hold_sample_end", int'(sample), last_s);
        en = 1'b1;
        measure_first();

        // random densities, some loud
        mode = 4;
        for (int i = 0; i < 10; i++) begin
            dens = int'($urandom_range(0, 100));
            run_windows(1);
            if (i == 5) pulse_peak_clr();
        end

        // reset mid-window while holdoff is active
        mode = 1;
        run_windows(2);
        wait_bits(5);
        @(negedge clk); #2 rst = 1'b1;
        #1;
        chk("rst_mid_sample", int'(sample), 0);
        chk("rst_mid_level", int'(level), 0);
        chk("rst_mid_valid", int'(sample_valid), 0);
        chk("rst_mid_mic_clk", int'(mic_clk), 0);
        @(negedge clk); rst = 1'b0;
        measure_first();
        run_windows(2);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
